// File: rtl/demux_striping_pkg.sv
//==============================================================================
// demux_striping_pkg : widths, lane count, default depth and lane-selector state
// Rev 1.0
//==============================================================================
`default_nettype none

package demux_striping_pkg;

  localparam int DATA_W    = 32;
  localparam int LANE_CNT  = 2;
  localparam int DEPTH_DEF = 4;

  typedef enum logic [0:0] {
    LANE0 = 1'b0,
    LANE1 = 1'b1
  } lane_e;

endpackage

`default_nettype wire

// File: rtl/stripe_fifo.sv
//==============================================================================
// stripe_fifo : per-lane FIFO; head shows the oldest entry, or zero when empty
// Rev 1.0
//==============================================================================
`default_nettype none

module stripe_fifo
  import demux_striping_pkg::*;
#(
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WIDTH  = DATA_W
) (
  input  logic             clk_2f,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign full  = (count == FULL_CNT);
  assign empty = (count == '0);
  // A full FIFO refuses pushes even if it pops in the same cycle.
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  assign head    = empty ? '0 : mem[rd_ptr];

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/demux_striping.sv
//==============================================================================
// demux_striping : alternates accepted words between two lane FIFOs.
// Optional DEMUX_STRIPING_OVF_EN adds a sticky ovf_err flag for dropped words.
// Rev 1.0
//==============================================================================
`default_nettype none

module demux_striping
  import demux_striping_pkg::*;
#(
  parameter int DEPTH = DEPTH_DEF
) (
  input  logic              clk_2f,
  input  logic              reset,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic              in_ready,
  output logic [DATA_W-1:0] data_lane_0,
  output logic [DATA_W-1:0] data_lane_1,
  output logic              valid_lane_0,
  output logic              valid_lane_1,
  input  logic              ready_lane_0,
`ifdef DEMUX_STRIPING_OVF_EN
  input  logic              ready_lane_1,
  output logic              ovf_err
`else
  input  logic              ready_lane_1
`endif
);

  lane_e               state_q;
  lane_e               state_d;
  logic [LANE_CNT-1:0] push;
  logic [LANE_CNT-1:0] pop;
  logic [LANE_CNT-1:0] full;
  logic [LANE_CNT-1:0] empty;
  logic [LANE_CNT-1:0] ready_vec;
  logic [DATA_W-1:0]   head [LANE_CNT];

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      state_q <= LANE0;
    end else begin
      state_q <= state_d;
    end
  end

  // in_ready depends only on registered state so it never loops back through valid_in.
  always_comb begin
    state_d  = state_q;
    push     = '0;
    in_ready = 1'b0;
    case (state_q)
      LANE0: begin
        in_ready = ~full[0];
        if (valid_in && in_ready) begin
          push[0] = 1'b1;
          state_d = LANE1;
        end
      end
      LANE1: begin
        in_ready = ~full[1];
        if (valid_in && in_ready) begin
          push[1] = 1'b1;
          state_d = LANE0;
        end
      end
      default: state_d = LANE0;
    endcase
  end

  assign ready_vec = {ready_lane_1, ready_lane_0};
  assign pop       = ready_vec & ~empty;

  generate
    for (genvar g = 0; g < LANE_CNT; g++) begin : g_lane
      stripe_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (DATA_W)
      ) u_fifo (
        .clk_2f    (clk_2f),
        .reset     (reset),
        .push      (push[g]),
        .push_data (data_in),
        .pop       (pop[g]),
        .full      (full[g]),
        .empty     (empty[g]),
        .head      (head[g])
      );
    end
  endgenerate

  assign data_lane_0  = head[0];
  assign data_lane_1  = head[1];
  assign valid_lane_0 = ~empty[0];
  assign valid_lane_1 = ~empty[1];

`ifdef DEMUX_STRIPING_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk_2f) begin
    if (reset) begin
      ovf_q <= 1'b0;
    end else if (valid_in && !in_ready) begin
      ovf_q <= 1'b1;
    end
  end

  assign ovf_err = ovf_q;
`endif

endmodule

`default_nettype wire

// File: doc/demux_striping.md
DEMUX_STRIPING -- requirements
Module: demux_striping

Interface
REQ-001 The block SHALL have parameter DEPTH, default 4, giving per-lane FIFO entries (power of 2, minimum 2).
REQ-002 The block SHALL have port clk_2f, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: reset is synchronous and active-high.
REQ-004 The block SHALL have port data_in, input, 32 bits: the striped word stream.
REQ-005 The block SHALL have port valid_in, input, 1 bit: data_in holds a word this cycle.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the currently selected lane can accept a word.
REQ-007 The block SHALL have ports data_lane_0 and data_lane_1, output, 32 bits each: head word of each lane FIFO.
REQ-008 The block SHALL have ports valid_lane_0 and valid_lane_1, output, 1 bit each: the lane FIFO is non-empty.
REQ-009 The block SHALL have ports ready_lane_0 and ready_lane_1, input, 1 bit each: the consumer takes the lane head word this cycle.
REQ-010 When DEMUX_STRIPING_OVF_EN is defined, the block SHALL have port ovf_err, output, 1 bit: sticky dropped-word flag.

Function
REQ-011 The block SHALL accept a word when valid_in=1 and in_ready=1 (accept event).
REQ-012 The lane selector SHALL be a 2-state FSM, LANE0 and LANE1: LANE0 -> LANE1 and LANE1 -> LANE0 on each accept event only, holding otherwise.
REQ-013 On an accept event, the block SHALL push data_in into the FIFO of the current FSM lane.
REQ-014 in_ready SHALL equal NOT full of the current-state lane FIFO, derived from registered state only.
REQ-015 A push into a full FIFO SHALL be blocked even when the same lane pops in that cycle (no full-bypass).
REQ-016 valid_lane_N SHALL be 1 exactly when FIFO N is non-empty; data_lane_N SHALL show the head entry, or 32'h0 when empty.
REQ-017 A word accepted at edge k SHALL appear on its lane outputs immediately after edge k (1-cycle latency).
REQ-018 A pop SHALL occur when valid_lane_N=1 and ready_lane_N=1; ready_lane_N while empty SHALL be ignored.
REQ-019 Simultaneous push and pop on a non-full, non-empty FIFO SHALL keep its occupancy unchanged and preserve order.
REQ-020 FIFO pointers SHALL wrap modulo DEPTH; occupancy SHALL range over 0..DEPTH and use $clog2(DEPTH)+1 bits.
REQ-021 Lanes SHALL be independent: a stalled lane SHALL never block pops from the other lane.
REQ-022 valid_in=1 with in_ready=0 SHALL drop the word and leave the FSM state unchanged.

Reset
REQ-023 With reset=1 at a clock edge, the FSM SHALL go to LANE0 and both FIFOs SHALL empty, discarding contents.
REQ-024 The cycle after reset, outputs SHALL be in_ready=1, valid_lane_0=0, valid_lane_1=0, data_lane_0=0, data_lane_1=0, and ovf_err=0 when present.
REQ-025 Reset asserted mid-stream SHALL take priority over same-cycle accept and pop events.

Configuration
REQ-026 With DEMUX_STRIPING_OVF_EN defined, a drop per REQ-022 SHALL set ovf_err=1 from the next cycle until reset.
REQ-027 Without DEMUX_STRIPING_OVF_EN, the ovf_err port and its logic SHALL be absent, and drops SHALL be silent.

Structure
REQ-028 A shared package demux_striping_pkg SHALL hold DATA_W=32, LANE_CNT=2, DEPTH_DEF=4, and the FSM state typedef (LANE0=0, LANE1=1).
REQ-029 Per-lane storage SHALL be one sub-module, stripe_fifo, instantiated twice, with push/pop/full/empty/head ports.

Verification
REQ-030 The bench SHALL cover: reset, then A0, A1, A2, A3 on consecutive cycles with both ready_lane=1 -> lane0 gets A0, A2; lane1 gets A1, A3; each valid one cycle after acceptance.
REQ-031 The bench SHALL cover: ready_lane_0=0, 8 consecutive words, DEPTH=4 -> in_ready drops after the 4th lane0 push while in LANE0; lane1 holds 4 words; no word lost.
REQ-032 The bench SHALL cover: a drop with the macro defined (valid_in=1, in_ready=0) -> ovf_err=1 next cycle and sticky; FSM unchanged; without the macro, no port and no lane change.
REQ-033 The bench SHALL cover: lane0 full, with push and pop in the same cycle -> push refused, occupancy becomes 3, and order is kept.
REQ-034 The bench SHALL cover: reset asserted with both FIFOs half full -> next cycle both valid_lane=0, in_ready=1, and the next word goes to lane0.
REQ-035 The bench SHALL cover: idle valid_in gaps of 1-3 cycles between words -> lane alternation is unaffected by the gaps.
